fifo_line_reader: RTL



---
 rtl/fifo_line_reader_if.sv | 38 +++
 rtl/fifo_line_reader.sv | 117 +++++++++++
 2 files changed

// File: rtl/fifo_line_reader_if.sv
// rtl/fifo_line_reader_if.sv - Line-reader bus: FIFO read port, flush and output word stream
//
// Signals:
//   flush                            pipeline-wide synchronous flush
//   line_empty/line_data/line_addr/
//   line_mask/line_pop               FIFO head line and its pop strobe
//   out_valid/out_ready/out_word/
//   out_addr/out_last                registered per-word output stream
// Modports:
//   master  the line reader (drives line_pop and out_*)
//   slave   the surrounding FIFO/decode environment
interface fifo_line_reader_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
);
  logic                                 flush;
  logic                                 line_empty;
  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_data;
  logic [ADDR_WIDTH-1:0]                line_addr;
  logic [WORDS_PER_LINE-1:0]            line_mask;
  logic                                 line_pop;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [WORD_WIDTH-1:0]                out_word;
  logic [ADDR_WIDTH-1:0]                out_addr;
  logic                                 out_last;

  modport master (
    input  flush, line_empty, line_data, line_addr, line_mask, out_ready,
    output line_pop, out_valid, out_word, out_addr, out_last
  );

  modport slave (
    output flush, line_empty, line_data, line_addr, line_mask, out_ready,
    input  line_pop, out_valid, out_word, out_addr, out_last
  );
endinterface

// File: rtl/fifo_line_reader.sv
// rtl/fifo_line_reader.sv - Pops masked multi-word FIFO lines and issues valid words one per cycle
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fifo_line_reader_if.master: FIFO read port (line_*), flush,
//          and the out_* valid/ready word stream with per-word address and
//          end-of-line flag
module fifo_line_reader #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_line_reader_if.master  bus
);

  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);
  localparam int LINE_W         = WORD_WIDTH * WORDS_PER_LINE;

  // Hold stage: the popped line; hold_mask tracks words not yet issued.
  logic [LINE_W-1:0]         hold_data_q, hold_data_d;
  logic [ADDR_WIDTH-1:0]     hold_addr_q, hold_addr_d;
  logic [WORDS_PER_LINE-1:0] hold_mask_q, hold_mask_d;

  // Output stage.
  logic                      out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0]     out_word_q, out_word_d;
  logic [ADDR_WIDTH-1:0]     out_addr_q, out_addr_d;
  logic                      out_last_q, out_last_d;

  logic [IDX_W-1:0]          idx;
  logic                      out_fire;
  logic                      out_free;
  logic                      issue;
  logic                      single_left;
  logic [WORDS_PER_LINE-1:0] rem_next;
  logic                      pop;

  // Lowest set bit of the remaining mask; scanning downward lets the
  // lowest index win.
  always_comb begin
    idx = '0;
    for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
      if (hold_mask_q[i]) idx = IDX_W'(i);
    end
  end

  assign out_fire    = out_valid_q & bus.out_ready;
  assign out_free    = ~out_valid_q | bus.out_ready;
  assign issue       = (hold_mask_q != '0) & out_free & ~bus.flush;
  assign single_left = (hold_mask_q & (hold_mask_q - WORDS_PER_LINE'(1))) == '0;
  assign rem_next    = issue ? (hold_mask_q & ~(WORDS_PER_LINE'(1) << idx)) : hold_mask_q;

  // Refill the hold stage in the same cycle its last word issues so lines
  // stream without a bubble. Gated by rst_n so no pop escapes during reset.
  assign pop = rst_n & ~bus.line_empty & ~bus.flush & (rem_next == '0);

  always_comb begin
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    hold_mask_d = rem_next;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;

    if (pop) begin
      hold_data_d = bus.line_data;
      hold_addr_d = bus.line_addr;
      hold_mask_d = bus.line_mask;
    end

    if (issue) begin
      out_valid_d = 1'b1;
      out_word_d  = hold_data_q[idx*WORD_WIDTH +: WORD_WIDTH];
      out_addr_d  = hold_addr_q + (ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES_PER_WORD));
      out_last_d  = single_left;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (bus.flush) begin
      hold_mask_d = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_addr_q <= '0;
      hold_mask_q <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      hold_mask_q <= hold_mask_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.line_pop  = pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;

endmodule
